cpu_mem_responder: RTL and testbench
====================================

Name: cpu_mem_responder

Overview:
- Data-side responder for the single-cycle MIPS core's load/store interface: answers the core's mem_addr / mem_write_data / wren, returns mem_read_data.
- Contains a word-addressed data RAM plus a small MMIO window: keyboard receive FIFO, LED register, free-running cycle timer.
- Sits beside the core in the top level; instruction ROM stays separate.

Parameters:
- RAM_WORDS, 1024, number of 32-bit data RAM words (power of 2).
- MMIO_BASE, 32'h1000_0000, base byte address of the MMIO window.
- FIFO_DEPTH, 8, keyboard FIFO entries (power of 2, at least 2).
- LED_W, 16, LED register width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- mem_addr  in  32  byte address from core.
- mem_write_data  in  32  store data.
- wren  in  1  store strobe; write occurs on the clk rising edge.
- rden  in  1  load strobe; one cycle per executed load; gates MMIO read side effects.
- mem_read_data  out  32  combinational read data for mem_addr.
- kbd_valid  in  1  keyboard byte present this cycle (push).
- kbd_data  in  8  keyboard scan/ASCII byte.
- led  out  LED_W  LED register value.
- bus_err  out  1  one-cycle pulse on access to an unmapped address.

Behaviour:
- Address decode on mem_addr[31:2] (mem_addr[1:0] ignored; the core selects bytes itself, big-endian: offset 0 = bits [31:24]).
- RAM region: addr < RAM_WORDS*4.
  - Read is asynchronous: mem_read_data = ram[addr[..:2]] in the same cycle.
  - Write on posedge when wren.
  - RAM contents are not reset.
- MMIO region: MMIO_BASE + offset.
  - +0x00 KBD_STATUS (RO): bit0 = not_empty, bit1 = full, bit2 = overflow (sticky), bits[11:8] = count; other bits 0. A read with rden clears overflow at the edge.
  - +0x04 KBD_DATA (RO): {24'b0, head byte}; reads 0 when empty. rden pops one entry at the edge; a pop when empty has no effect.
  - +0x08 LED (RW): reads {zero-pad, led}; a write loads mem_write_data[LED_W-1:0].
  - +0x0C TIMER (RW): increments every cycle, wraps 2^32-1 -> 0. A write loads mem_write_data, and the next cycle continues from the loaded value + 1. A write beats the increment in the same cycle.
  - Writes to RO registers are ignored, with no bus_err.
- Unmapped address: read returns 0. When wren or rden is high, bus_err pulses high for one cycle (registered, visible the cycle after the access). No state changes.
- wren and rden both high: the write is performed, read side effects are suppressed, and mem_read_data is still driven.
- FIFO:
  - Push when kbd_valid and not full.
  - Push when full: byte dropped, overflow set.
  - Push and pop in the same cycle when full: both succeed, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: push accepted, pop ignored, read data = 0.
  - Pointers wrap modulo FIFO_DEPTH. Count is held in a separate register (0..FIFO_DEPTH).
  - If overflow-clear and a new overflow occur in the same cycle, set wins.
- Reset values: led = 0, bus_err = 0, FIFO empty (pointers and count 0), overflow = 0, timer = 0. mem_read_data follows decode, i.e. RAM contents or 0 for MMIO reset values.
- Reset asserted mid-operation overrides any concurrent write, push or pop in that cycle.

Decomposition:
- Shared package cpu_mem_pkg: MMIO offset constants (KBD_STATUS, KBD_DATA, LED, TIMER) and status bit indices. The core and software headers use the same values.
- One sub-module: kbd_fifo (push/pop/full/empty/count/head, synchronous reset). Everything else is flat in cpu_mem_responder.

Test Plan:
- RAM round trip: wren to 0x0000_0010 with data 32'hDEAD_BEEF, then read 0x10 (and 0x13) -> mem_read_data = 32'hDEAD_BEEF in the same cycle. Also check the last word (RAM_WORDS*4-4).
- FIFO order: push 0x41, 0x42, 0x43. STATUS -> not_empty=1, count=3. Three KBD_DATA reads with rden -> 0x41, 0x42, 0x43. STATUS then -> 0. A fourth rden read -> 0, with no underflow.
- Overflow: push 9 bytes with FIFO_DEPTH=8 -> full=1, overflow=1, the ninth byte lost. STATUS read with rden clears overflow. Push and pop in the same cycle while full -> count stays 8, overflow stays 0.
- LED / timer: write LED 32'h0001_A5A5 -> led = 16'hA5A5. Write TIMER 32'hFFFF_FFFE -> reads FFFF_FFFF next cycle, then 0000_0000 (wrap).
- Unmapped: rden at 0x2000_0000 -> mem_read_data = 0 and bus_err high for exactly one cycle. A wren there changes no RAM or register.
- Reset mid-operation: assert rst in the same cycle as a LED write and a kbd push -> led = 0, FIFO empty, timer = 0 after the edge.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared constants for the MIPS data-side memory map.
// MMIO register byte offsets (relative to the MMIO window base), keyboard
// status bit positions, and the address-region type used by the responder's
// decoder. Core-side software headers mirror these values.
package cpu_mem_pkg;

  // MMIO register byte offsets
  localparam logic [31:0] KBD_STATUS_OFS = 32'h0000_0000;
  localparam logic [31:0] KBD_DATA_OFS   = 32'h0000_0004;
  localparam logic [31:0] LED_OFS        = 32'h0000_0008;
  localparam logic [31:0] TIMER_OFS      = 32'h0000_000C;

  // KBD_STATUS bit layout
  localparam int unsigned STAT_NOT_EMPTY_BIT = 0;
  localparam int unsigned STAT_FULL_BIT      = 1;
  localparam int unsigned STAT_OVERFLOW_BIT  = 2;
  localparam int unsigned STAT_COUNT_LSB     = 8;
  localparam int unsigned STAT_COUNT_W       = 4;

  // Decoded target of the current access
  typedef enum logic [2:0] {
    REG_NONE,
    REG_RAM,
    REG_KBD_STATUS,
    REG_KBD_DATA,
    REG_LED,
    REG_TIMER
  } region_e;

  // Word address (addr[31:2]) of an MMIO register
  function automatic logic [29:0] mmio_word(input logic [31:0] base,
                                            input logic [31:0] ofs);
    logic [31:0] byte_addr;
    byte_addr = base + ofs;
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/cpu_mem_responder_kbd_fifo.sv
// Keyboard receive FIFO.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   push, din        enqueue request and byte
//   pop              dequeue request (ignored when empty)
//   full_c, empty_c  combinational occupancy flags
//   count            registered occupancy, 0..DEPTH
//   head_c           combinational oldest entry
// A push while full is accepted only if a pop happens in the same cycle.
module kbd_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [DATA_W-1:0]              din,
  output logic                           full_c,
  output logic                           empty_c,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic [DATA_W-1:0]              head_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Occupancy flags and accepted operations
  always_comb begin
    full_c  = (count == CNT_W'(DEPTH));
    empty_c = (count == '0);
    do_pop  = pop & ~empty_c;
    do_push = push & (~full_c | pop);
    head_c  = mem[rd_ptr];
  end

  // Storage; when full with a concurrent pop, the write reuses the slot being freed
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// Data-side load/store responder for the single-cycle MIPS core.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   mem_addr        byte address from the core (bits [1:0] ignored)
//   mem_write_data  store data
//   wren            store strobe, write at the rising edge
//   rden            load strobe, enables MMIO read side effects
//   mem_read_data   combinational read data for mem_addr
//   kbd_valid/data  keyboard byte push
//   led             LED register
//   bus_err         registered one-cycle pulse after an unmapped access
// Map: word RAM at 0, MMIO window at MMIO_BASE (KBD_STATUS, KBD_DATA, LED,
// TIMER). Everything else reads 0 and flags bus_err when strobed.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LED_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_write_data,
  input  logic              wren,
  input  logic              rden,
  output logic [31:0]       mem_read_data,
  input  logic              kbd_valid,
  input  logic [7:0]        kbd_data,
  output logic [LED_W-1:0]  led,
  output logic              bus_err
);

  localparam int unsigned RAM_IDX_W = $clog2(RAM_WORDS);
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);

  localparam logic [29:0] STATUS_WORD = mmio_word(MMIO_BASE, KBD_STATUS_OFS);
  localparam logic [29:0] DATA_WORD   = mmio_word(MMIO_BASE, KBD_DATA_OFS);
  localparam logic [29:0] LED_WORD    = mmio_word(MMIO_BASE, LED_OFS);
  localparam logic [29:0] TIMER_WORD  = mmio_word(MMIO_BASE, TIMER_OFS);

  logic [29:0]          word_addr;
  logic [RAM_IDX_W-1:0] ram_idx;
  logic                 unused_byte_sel;
  region_e              region;

  logic [31:0]          ram [RAM_WORDS];
  logic [31:0]          timer;
  logic                 overflow;
  logic [31:0]          status_word;

  logic                 rd_fx;
  logic                 kbd_pop;
  logic                 ovf_set;
  logic                 ovf_clr;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic [7:0]           fifo_head;

  // Byte lanes are selected by the core; only the word address matters here
  assign word_addr       = mem_addr[31:2];
  assign ram_idx         = word_addr[RAM_IDX_W-1:0];
  assign unused_byte_sel = ^mem_addr[1:0];

  // Address decode; RAM takes priority if the windows ever overlap
  always_comb begin
    region = REG_NONE;
    if (word_addr < 30'(RAM_WORDS))  region = REG_RAM;
    else if (word_addr == STATUS_WORD) region = REG_KBD_STATUS;
    else if (word_addr == DATA_WORD)   region = REG_KBD_DATA;
    else if (word_addr == LED_WORD)    region = REG_LED;
    else if (word_addr == TIMER_WORD)  region = REG_TIMER;
  end

  // Read side effects only on a pure load; a concurrent store suppresses them
  always_comb begin
    rd_fx   = rden & ~wren;
    kbd_pop = rd_fx & (region == REG_KBD_DATA);
    ovf_clr = rd_fx & (region == REG_KBD_STATUS);
    // A full FIFO is never empty, so a requested pop always frees a slot
    ovf_set = kbd_valid & fifo_full & ~kbd_pop;
  end

  kbd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_kbd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (kbd_valid),
    .pop     (kbd_pop),
    .din     (kbd_data),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .count   (fifo_count),
    .head_c  (fifo_head)
  );

  // KBD_STATUS assembly
  always_comb begin
    status_word = '0;
    status_word[STAT_NOT_EMPTY_BIT] = ~fifo_empty;
    status_word[STAT_FULL_BIT]      = fifo_full;
    status_word[STAT_OVERFLOW_BIT]  = overflow;
    status_word[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
  end

  // Combinational read mux
  always_comb begin
    mem_read_data = '0;
    unique case (region)
      REG_RAM:        mem_read_data = ram[ram_idx];
      REG_KBD_STATUS: mem_read_data = status_word;
      REG_KBD_DATA:   mem_read_data = fifo_empty ? 32'd0 : 32'(fifo_head);
      REG_LED:        mem_read_data = 32'(led);
      REG_TIMER:      mem_read_data = timer;
      default:        mem_read_data = '0;
    endcase
  end

  // Data RAM, not reset; reset still blocks a concurrent store
  always_ff @(posedge clk) begin
    if (!rst && wren && (region == REG_RAM)) begin
      ram[ram_idx] <= mem_write_data;
    end
  end

  // MMIO registers and bus error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      led      <= '0;
      timer    <= '0;
      overflow <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      bus_err <= (region == REG_NONE) & (wren | rden);
      if (wren && (region == REG_LED)) begin
        led <= mem_write_data[LED_W-1:0];
      end
      // A store beats the free-running increment
      if (wren && (region == REG_TIMER)) begin
        timer <= mem_write_data;
      end else begin
        timer <= timer + 32'd1;
      end
      // A new overflow wins over a concurrent clear
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed scenarios followed by
// randomized traffic, all compared against a queue/array reference model.
module tb_cpu_mem_responder;

  localparam int unsigned RAM_WORDS  = 1024;
  localparam logic [31:0] MMIO_BASE  = 32'h1000_0000;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned LED_W      = 16;

  localparam logic [31:0] A_STATUS = MMIO_BASE + 32'h0;
  localparam logic [31:0] A_DATA   = MMIO_BASE + 32'h4;
  localparam logic [31:0] A_LED    = MMIO_BASE + 32'h8;
  localparam logic [31:0] A_TIMER  = MMIO_BASE + 32'hC;
  localparam logic [31:0] A_LAST   = 32'(RAM_WORDS * 4 - 4);

  logic              clk;
  logic              rst;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_write_data;
  logic              wren;
  logic              rden;
  logic [31:0]       mem_read_data;
  logic              kbd_valid;
  logic [7:0]        kbd_data;
  logic [LED_W-1:0]  led;
  logic              bus_err;

  cpu_mem_responder #(
    .RAM_WORDS  (RAM_WORDS),
    .MMIO_BASE  (MMIO_BASE),
    .FIFO_DEPTH (FIFO_DEPTH),
    .LED_W      (LED_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .wren           (wren),
    .rden           (rden),
    .mem_read_data  (mem_read_data),
    .kbd_valid      (kbd_valid),
    .kbd_data       (kbd_data),
    .led            (led),
    .bus_err        (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0]      m_ram [RAM_WORDS];
  bit               m_ram_v [RAM_WORDS];
  logic [7:0]       m_q [$];
  logic             m_ovf;
  logic [LED_W-1:0] m_led;
  logic [31:0]      m_timer;
  logic             m_berr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic bit in_ram(input logic [31:0] a);
    return {2'b00, a[31:2]} < 32'(RAM_WORDS);
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic model_read(input logic [31:0] a, output logic [31:0] v, output bit known);
    logic [9:0] idx;
    known = 1'b1;
    v     = 32'd0;
    idx   = a[11:2];
    if (in_ram(a)) begin
      known = m_ram_v[idx];
      v     = m_ram[idx];
    end else begin
      case (word_of(a))
        A_STATUS: v = {20'h0, 4'(m_q.size()), 5'h0, m_ovf,
                       m_q.size() == FIFO_DEPTH, m_q.size() != 0};
        A_DATA:   v = (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0;
        A_LED:    v = 32'(m_led);
        A_TIMER:  v = m_timer;
        default:  v = 32'd0;
      endcase
    end
  endtask

  task automatic model_edge(input logic [31:0] a, input logic [31:0] d, input logic w,
                            input logic r, input logic kv, input logic [7:0] kd,
                            input logic rs);
    bit is_st, is_dt, is_ld, is_tm, is_rm, mapped, fx, was_full, popped, set;
    logic [9:0] idx;
    if (rs) begin
      m_led   = '0;
      m_q.delete();
      m_ovf   = 1'b0;
      m_timer = 32'd0;
      m_berr  = 1'b0;
      return;
    end
    idx    = a[11:2];
    is_rm  = in_ram(a);
    is_st  = !is_rm && word_of(a) == A_STATUS;
    is_dt  = !is_rm && word_of(a) == A_DATA;
    is_ld  = !is_rm && word_of(a) == A_LED;
    is_tm  = !is_rm && word_of(a) == A_TIMER;
    mapped = is_rm || is_st || is_dt || is_ld || is_tm;
    m_berr  = !mapped && (w || r);
    m_timer = (w && is_tm) ? d : m_timer + 32'd1;
    if (w && is_rm) begin
      m_ram[idx]   = d;
      m_ram_v[idx] = 1'b1;
    end
    if (w && is_ld) m_led = d[LED_W-1:0];
    fx       = r && !w;
    was_full = (m_q.size() == FIFO_DEPTH);
    popped   = 1'b0;
    if (fx && is_dt && m_q.size() != 0) begin
      void'(m_q.pop_front());
      popped = 1'b1;
    end
    set = 1'b0;
    if (kv) begin
      if (!was_full || popped) m_q.push_back(kd);
      else set = 1'b1;
    end
    if (set) m_ovf = 1'b1;
    else if (fx && is_st) m_ovf = 1'b0;
  endtask

  // One bus cycle: drive, check the combinational read, clock, check registers
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w,
                      input logic r, input logic kv, input logic [7:0] kd,
                      input logic rs);
    logic [31:0] ev;
    bit known;
    mem_addr       = a;
    mem_write_data = d;
    wren           = w;
    rden           = r;
    kbd_valid      = kv;
    kbd_data       = kd;
    rst            = rs;
    #2;
    model_read(a, ev, known);
    if (known && !rs) check($sformatf("rdata@%h", a), mem_read_data, ev);
    @(posedge clk);
    model_edge(a, d, w, r, kv, kd, rs);
    #1;
    check("led", 32'(led), 32'(m_led));
    check("bus_err", 32'(bus_err), 32'(m_berr));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(a, d, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask
  task automatic rd(input logic [31:0] a);
    step(a, 32'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask
  task automatic peek(input logic [31:0] a);
    step(a, 32'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask
  task automatic push(input logic [7:0] b);
    step(A_LED, 32'd0, 1'b0, 1'b0, 1'b1, b, 1'b0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic w, r, kv, rs;
    bit drain;
    for (int i = 0; i < RAM_WORDS; i++) m_ram_v[i] = 1'b0;
    mem_addr = 32'd0; mem_write_data = 32'd0; wren = 1'b0; rden = 1'b0;
    kbd_valid = 1'b0; kbd_data = 8'h00; rst = 1'b1;
    repeat (2) @(posedge clk);
    m_led = '0; m_q.delete(); m_ovf = 1'b0; m_timer = 32'd0; m_berr = 1'b0;
    #1;
    check("rst_led", 32'(led), 32'(m_led));
    check("rst_bus_err", 32'(bus_err), 32'(m_berr));
    peek(A_TIMER);
    peek(A_STATUS);
    peek(A_DATA);

    // RAM round trip, including byte-offset alias and the last word
    wr(32'h10, 32'hDEAD_BEEF);
    peek(32'h10);
    peek(32'h13);
    wr(A_LAST, 32'h1234_5678);
    peek(A_LAST);

    // FIFO ordering and empty pop
    push(8'h41); push(8'h42); push(8'h43);
    peek(A_STATUS);
    rd(A_DATA); rd(A_DATA); rd(A_DATA);
    peek(A_STATUS);
    rd(A_DATA);
    peek(A_STATUS);

    // Overflow, sticky clear, push+pop while full
    for (int i = 0; i < 9; i++) push(8'(8'h60 + i));
    peek(A_STATUS);
    rd(A_STATUS);
    peek(A_STATUS);
    step(A_DATA, 32'd0, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
    peek(A_STATUS);
    peek(A_DATA);

    // LED and timer wrap
    wr(A_LED, 32'h0001_A5A5);
    peek(A_LED);
    wr(A_TIMER, 32'hFFFF_FFFE);
    peek(A_TIMER); peek(A_TIMER); peek(A_TIMER);

    // Unmapped access
    rd(32'h2000_0000);
    peek(32'h2000_0000);
    wr(32'h2000_0000, 32'hFFFF_FFFF);
    peek(A_LED);
    wr(MMIO_BASE + 32'h10, 32'h5555_5555);
    wr(A_STATUS, 32'hFFFF_FFFF);
    peek(A_STATUS);

    // Reset colliding with a LED store and a keyboard push
    step(A_LED, 32'h0000_1234, 1'b1, 1'b0, 1'b1, 8'h99, 1'b1);
    peek(A_STATUS);
    peek(A_TIMER);
    peek(32'h10);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drain = ((i / 300) % 2) == 1;
      case ($urandom_range(0, 9))
        0, 1:    a = {20'h0, 6'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
        2:       a = A_LAST | 32'($urandom_range(0, 3));
        3:       a = A_STATUS;
        4:       a = A_DATA;
        5:       a = A_LED;
        6:       a = A_TIMER;
        7:       a = ($urandom_range(0, 1) == 0) ? MMIO_BASE + 32'h10 : 32'h2000_0000;
        default: a = $urandom;
      endcase
      if (drain && $urandom_range(0, 1) == 0) a = A_DATA;
      d  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFD : $urandom;
      w  = ($urandom_range(0, 3) == 0);
      r  = drain ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 2) == 0);
      kv = drain ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 0);
      rs = ($urandom_range(0, 199) == 0);
      step(a, d, w, r, kv, 8'($urandom), rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
